// File: rtl/led_display_package.sv
// led_display_package: shared scan FSM states, default panel geometry
// and the row-data bit index function for the HUB75 driver.
package led_display_package;

  localparam int GL_NUM_COL_PIXELS = 64;
  localparam int GL_NUM_ROW_PIXELS = 32;
  localparam int GL_COLOR_DEPTH    = 4;
  localparam int GL_BASE_ON        = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LATCH,
    ST_DISPLAY
  } scan_state_t;

  // half: 1=top 0=bot; colour: red=2 green=1 blue=0
  function automatic int row_bit(
    input int half,
    input int colour,
    input int col,
    input int plane,
    input int ncols,
    input int depth
  );
    return ((half * 3 + colour) * ncols + col) * depth + plane;
  endfunction

endpackage

// File: rtl/led_bcm_timer.sv
// led_bcm_timer: binary-coded-modulation plane timer; counts the
// DISPLAY length of the current plane and gates OE by brightness.
module led_bcm_timer
  import led_display_package::*;
#(
  parameter int BASE_ON     = GL_BASE_ON,
  parameter int COLOR_DEPTH = GL_COLOR_DEPTH,
  parameter int PW          = 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          run_i,
  input  logic [PW-1:0] plane_i,
  input  logic [7:0]    bright_i,
  output logic          oe_on_o,
  output logic          done_o
);

  // sized so the longest plane (BASE_ON<<(COLOR_DEPTH-1)) fits
  localparam int TW  = $clog2((BASE_ON << (COLOR_DEPTH - 1)) + 1);
  localparam int PRW = TW + 9;

  logic [TW-1:0]  cnt_q;
  logic [TW-1:0]  len;
  logic [PRW-1:0] lim;

  // plane length, end-of-plane and brightness-scaled OE window
  always_comb begin
    len     = TW'(BASE_ON) << plane_i;
    lim     = (PRW'(len) * PRW'({1'b0, bright_i} + 9'd1)) >> 8;
    done_o  = run_i && (cnt_q == len - 1'b1);
    oe_on_o = run_i && (PRW'(cnt_q) < lim);
  end

  // elapsed-cycle counter, cleared outside DISPLAY and at plane end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      cnt_q <= '0;
    else if (!run_i || done_o)
      cnt_q <= '0;
    else
      cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/hub75_scan_driver.sv
// hub75_scan_driver: shifts one row pair per plane, latches, then shows
// it for BASE_ON<<plane clocks. LED_DISPLAY_BRIGHTNESS_EN adds brightness_i.
module hub75_scan_driver
  import led_display_package::*;
#(
  parameter  int NUM_COLS    = GL_NUM_COL_PIXELS,
  parameter  int NUM_ROWS    = GL_NUM_ROW_PIXELS,
  parameter  int COLOR_DEPTH = GL_COLOR_DEPTH,
  parameter  int BASE_ON     = GL_BASE_ON,
  localparam int RW = (NUM_ROWS > 2) ? $clog2(NUM_ROWS / 2) : 1,
  localparam int DW = 6 * NUM_COLS * COLOR_DEPTH
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [DW-1:0] row_data_i,
  input  logic          row_valid_i,
`ifdef LED_DISPLAY_BRIGHTNESS_EN
  input  logic [7:0]    brightness_i,
`endif
  output logic          row_ready_o,
  output logic [RW-1:0] row_idx_o,
  output logic          frame_start_o,
  output logic [2:0]    rgb_top_o,
  output logic [2:0]    rgb_bot_o,
  output logic          panel_clk_o,
  output logic          panel_lat_o,
  output logic          panel_oe_n_o,
  output logic [RW-1:0] row_addr_o
);

  localparam int CW = $clog2(NUM_COLS);
  localparam int PW = (COLOR_DEPTH > 1) ? $clog2(COLOR_DEPTH) : 1;
  localparam int IW = $clog2(DW);
  localparam int LAST_ROW = NUM_ROWS / 2 - 1;

  scan_state_t   state_q;
  scan_state_t   state_d;
  logic [DW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic [PW-1:0] plane_q;
  logic [7:0]    bright_q;
  logic [7:0]    bright_in;
  logic          phase_q;
  logic          rdy_en_q;
  logic          accept;
  logic          last_plane;
  logic          oe_on;
  logic          bcm_done;

`ifdef LED_DISPLAY_BRIGHTNESS_EN
  assign bright_in = brightness_i;
`else
  assign bright_in = 8'hFF;
`endif

  // rdy_en_q holds ready low until the first clock after reset
  assign row_ready_o   = rdy_en_q && (state_q == ST_IDLE);
  assign accept        = row_valid_i && row_ready_o;
  assign frame_start_o = accept && (row_idx_o == '0);
  assign last_plane    = (plane_q == PW'(COLOR_DEPTH - 1));

  led_bcm_timer #(
    .BASE_ON     (BASE_ON),
    .COLOR_DEPTH (COLOR_DEPTH),
    .PW          (PW)
  ) u_bcm (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .run_i    (state_q == ST_DISPLAY),
    .plane_i  (plane_q),
    .bright_i (bright_q),
    .oe_on_o  (oe_on),
    .done_o   (bcm_done)
  );

  // scan state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // next state and panel pins, idle values by default
  always_comb begin
    state_d      = state_q;
    panel_clk_o  = 1'b0;
    panel_lat_o  = 1'b0;
    panel_oe_n_o = 1'b1;
    rgb_top_o    = '0;
    rgb_bot_o    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept)
          state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        panel_clk_o = phase_q;
        for (int c = 0; c < 3; c++) begin
          rgb_top_o[c] = row_q[IW'(row_bit(1, c, int'(col_q),
                               int'(plane_q), NUM_COLS, COLOR_DEPTH))];
          rgb_bot_o[c] = row_q[IW'(row_bit(0, c, int'(col_q),
                               int'(plane_q), NUM_COLS, COLOR_DEPTH))];
        end
        if (phase_q && col_q == '0)
          state_d = ST_LATCH;
      end
      ST_LATCH: begin
        panel_lat_o = 1'b1;
        state_d     = ST_DISPLAY;
      end
      ST_DISPLAY: begin
        panel_oe_n_o = !oe_on;
        if (bcm_done)
          state_d = last_plane ? ST_IDLE : ST_SHIFT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // row capture, column/plane walk and row index bookkeeping
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rdy_en_q   <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      phase_q    <= 1'b0;
      plane_q    <= '0;
      bright_q   <= '0;
      row_idx_o  <= '0;
      row_addr_o <= '0;
    end else begin
      rdy_en_q <= 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            row_q    <= row_data_i;
            col_q    <= CW'(NUM_COLS - 1);
            phase_q  <= 1'b0;
            plane_q  <= '0;
            bright_q <= bright_in;
          end
        end
        ST_SHIFT: begin
          phase_q <= ~phase_q;
          if (phase_q)
            col_q <= col_q - 1'b1;
        end
        ST_LATCH: begin
          if (plane_q == '0)
            row_addr_o <= row_idx_o;
        end
        ST_DISPLAY: begin
          if (bcm_done) begin
            if (last_plane) begin
              row_idx_o <= (row_idx_o == RW'(LAST_ROW)) ?
                           '0 : row_idx_o + 1'b1;
            end else begin
              plane_q <= plane_q + 1'b1;
              col_q   <= CW'(NUM_COLS - 1);
              phase_q <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_scan_driver.sv
// tb_hub75_scan_driver: scoreboard bench for the HUB75 scan driver
// (4x4 panel, 2 planes, BASE_ON 8).
`timescale 1ns/1ps
module tb_hub75_scan_driver;

  localparam int NC = 4;
  localparam int NR = 4;
  localparam int CD = 2;
  localparam int BO = 8;
  localparam int DW = 6 * NC * CD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] row_data = '0;
  logic          row_valid = 1'b0;
`ifdef LED_DISPLAY_BRIGHTNESS_EN
  logic [7:0]    brightness = 8'hFF;
`endif
  logic          row_ready;
  logic [0:0]    row_idx;
  logic          frame_start;
  logic [2:0]    rgb_top;
  logic [2:0]    rgb_bot;
  logic          panel_clk;
  logic          panel_lat;
  logic          panel_oe_n;
  logic [0:0]    row_addr;

  int vectors = 0;
  int errors  = 0;
  int exp_idx = 0;
  int lat_count = 0;
  logic [5:0] exp_pix[$];
  logic [5:0] obs_pix[$];
  int exp_oe[$];
  int obs_oe[$];

  hub75_scan_driver #(
    .NUM_COLS    (NC),
    .NUM_ROWS    (NR),
    .COLOR_DEPTH (CD),
    .BASE_ON     (BO)
  ) dut (
    .clk_i         (clk),
    .reset_i       (rst),
    .row_data_i    (row_data),
    .row_valid_i   (row_valid),
`ifdef LED_DISPLAY_BRIGHTNESS_EN
    .brightness_i  (brightness),
`endif
    .row_ready_o   (row_ready),
    .row_idx_o     (row_idx),
    .frame_start_o (frame_start),
    .rgb_top_o     (rgb_top),
    .rgb_bot_o     (rgb_bot),
    .panel_clk_o   (panel_clk),
    .panel_lat_o   (panel_lat),
    .panel_oe_n_o  (panel_oe_n),
    .row_addr_o    (row_addr)
  );

  always #5 clk = ~clk;

  // expected {top,bot} pins for one column of one plane
  function automatic logic [5:0] pix(input logic [DW-1:0] d,
                                     input int col, input int p);
    logic [5:0] r;
    for (int h = 0; h < 2; h++)
      for (int c = 0; c < 3; c++)
        r[h * 3 + c] = d[((h * 3 + c) * NC + col) * CD + p];
    return r;
  endfunction

  task automatic push_row(input logic [DW-1:0] d, input int b);
    for (int p = 0; p < CD; p++) begin
      for (int col = NC - 1; col >= 0; col--)
        exp_pix.push_back(pix(d, col, p));
      exp_oe.push_back(((BO << p) * (b + 1)) >> 8);
    end
  endtask

  task automatic send_row(input logic [DW-1:0] d, output bit ok,
                          output logic idx, output logic fs);
    int n = 0;
    @(negedge clk);
    row_data  = d;
    row_valid = 1'b1;
    #1;
    while (!row_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    ok  = row_ready;
    idx = row_idx;
    fs  = frame_start;
    @(negedge clk);
    row_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (!row_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok = row_ready;
    repeat (2) @(negedge clk);
  endtask

  // pin monitor: collects shifted pixels and OE runs, checks overlaps
  logic prev_clk = 1'b0;
  logic prev_lat = 1'b0;
  logic prev_rst = 1'b1;
  logic [0:0] prev_addr = '0;
  int oe_run = 0;
  always @(negedge clk) begin
    if (!rst && !prev_rst) begin
      vectors++;
      if (!panel_oe_n && (panel_lat || panel_clk != prev_clk)) begin
        errors++;
        $display("FAIL oe_overlap: oe_n=%0b lat=%0b clk %0b->%0b, required oe_n=1",
                 panel_oe_n, panel_lat, prev_clk, panel_clk);
      end
      vectors++;
      if (row_addr != prev_addr && !prev_lat) begin
        errors++;
        $display("FAIL row_addr_change: %0d->%0d outside latch", prev_addr, row_addr);
      end
      if (panel_clk && !prev_clk)
        obs_pix.push_back({rgb_top, rgb_bot});
      if (!panel_oe_n)
        oe_run++;
      else if (oe_run > 0) begin
        obs_oe.push_back(oe_run);
        oe_run = 0;
      end
      if (panel_lat)
        lat_count++;
    end else
      oe_run = 0;
    prev_clk  = panel_clk;
    prev_lat  = panel_lat;
    prev_rst  = rst;
    prev_addr = row_addr;
  end

  task automatic test_reset;
    rst = 1'b1;
    row_valid = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if (row_ready !== 1'b0 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL rst_ready: ready=%0b fs=%0b required 0 0", row_ready, frame_start);
    end
    vectors++;
    if (panel_oe_n !== 1'b1 || panel_lat !== 1'b0 || panel_clk !== 1'b0) begin
      errors++;
      $display("FAIL rst_panel: oe_n=%0b lat=%0b clk=%0b required 1 0 0",
               panel_oe_n, panel_lat, panel_clk);
    end
    vectors++;
    if ({rgb_top, rgb_bot} !== 6'b0 || row_addr !== 1'b0 || row_idx !== 1'b0) begin
      errors++;
      $display("FAIL rst_data: rgb=%b addr=%0d idx=%0d required 0",
               {rgb_top, rgb_bot}, row_addr, row_idx);
    end
    row_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (row_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_release_ready: got %0b required 0", row_ready);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (row_ready !== 1'b1 || row_idx !== 1'b0) begin
      errors++;
      $display("FAIL rst_first_clock: ready=%0b idx=%0d required 1 0", row_ready, row_idx);
    end
  endtask

  task automatic test_row(input string nm, input logic [DW-1:0] d,
                          input int b, input logic eidx);
    bit ok;
    logic idx, fs;
    logic [5:0] e, o;
    int eo, oo;
    obs_pix.delete();
    obs_oe.delete();
    push_row(d, b);
    send_row(d, ok, idx, fs);
`ifdef LED_DISPLAY_BRIGHTNESS_EN
    brightness = 8'd10;
`endif
    vectors++;
    if (!ok || idx !== eidx || fs !== (eidx == 1'b0)) begin
      errors++;
      $display("FAIL %s_accept: ok=%0b idx=%0d fs=%0b required 1 %0d %0b",
               nm, ok, idx, fs, eidx, eidx == 1'b0);
    end
    wait_idle(ok);
    vectors++;
    if (!ok || row_idx !== ~eidx) begin
      errors++;
      $display("FAIL %s_idle: ok=%0b idx=%0d required 1 %0d", nm, ok, row_idx, ~eidx);
    end
    vectors++;
    if (obs_pix.size() != exp_pix.size()) begin
      errors++;
      $display("FAIL %s_pix_count: got %0d required %0d", nm, obs_pix.size(), exp_pix.size());
    end
    while (exp_pix.size() > 0) begin
      e = exp_pix.pop_front();
      o = 6'bx;
      if (obs_pix.size() > 0) o = obs_pix.pop_front();
      vectors++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s_pix: got %b required %b", nm, o, e);
      end
    end
    while (exp_oe.size() > 0) begin
      eo = exp_oe.pop_front();
      oo = -1;
      if (obs_oe.size() > 0) oo = obs_oe.pop_front();
      vectors++;
      if (oo != eo) begin
        errors++;
        $display("FAIL %s_oe_len: got %0d required %0d", nm, oo, eo);
      end
    end
    exp_idx = (exp_idx + 1) % 2;
  endtask

  task automatic test_red_row;
    logic [DW-1:0] d = '0;
    for (int col = 0; col < NC; col++)
      for (int p = 0; p < CD; p++)
        d[((1 * 3 + 2) * NC + col) * CD + p] = 1'b1;
    test_row("red", d, 255, 1'(exp_idx));
  endtask

  task automatic test_mixed_row;
    test_row("mixed", DW'({$urandom(), $urandom()}), 255, 1'(exp_idx));
  endtask

  task automatic test_back_to_back;
    int acc = 0;
    int n = 0;
    bit ok;
    logic [DW-1:0] d;
    logic [5:0] e, o;
    int eo, oo;
    obs_pix.delete();
    obs_oe.delete();
    d = DW'({$urandom(), $urandom()});
    @(negedge clk);
    row_data  = d;
    row_valid = 1'b1;
    while (acc < 4 && n < 400) begin
      #1;
      if (row_ready) begin
        vectors++;
        if (row_idx !== 1'(exp_idx) || frame_start !== (exp_idx == 0)) begin
          errors++;
          $display("FAIL b2b_accept%0d: idx=%0d fs=%0b required %0d %0b",
                   acc, row_idx, frame_start, exp_idx, exp_idx == 0);
        end
        push_row(d, 255);
        exp_idx = (exp_idx + 1) % 2;
        acc++;
        @(negedge clk);
        d = DW'({$urandom(), $urandom()});
        row_data = d;
        if (acc == 4) row_valid = 1'b0;
      end else
        @(negedge clk);
      n++;
    end
    row_valid = 1'b0;
    vectors++;
    if (acc != 4) begin
      errors++;
      $display("FAIL b2b_accepts: got %0d required 4", acc);
    end
    wait_idle(ok);
    vectors++;
    if (!ok || row_addr !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle: ok=%0b addr=%0d required 1 1", ok, row_addr);
    end
    while (exp_pix.size() > 0) begin
      e = exp_pix.pop_front();
      o = 6'bx;
      if (obs_pix.size() > 0) o = obs_pix.pop_front();
      vectors++;
      if (o !== e) begin
        errors++;
        $display("FAIL b2b_pix: got %b required %b", o, e);
      end
    end
    while (exp_oe.size() > 0) begin
      eo = exp_oe.pop_front();
      oo = -1;
      if (obs_oe.size() > 0) oo = obs_oe.pop_front();
      vectors++;
      if (oo != eo) begin
        errors++;
        $display("FAIL b2b_oe_len: got %0d required %0d", oo, eo);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    logic idx, fs;
    int n = 0;
    int lat0;
    send_row(DW'({$urandom(), $urandom()}), ok, idx, fs);
    while (!panel_lat && n < 50) begin @(negedge clk); n++; end
    while (panel_oe_n && n < 100) begin @(negedge clk); n++; end
    while (!panel_oe_n && n < 150) begin @(negedge clk); n++; end
    vectors++;
    if (!ok || n >= 150) begin
      errors++;
      $display("FAIL midrst_reach: ok=%0b cycles=%0d required 1 <150", ok, n);
    end
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    vectors++;
    if (panel_oe_n !== 1'b1 || panel_lat !== 1'b0 || panel_clk !== 1'b0 ||
        {rgb_top, rgb_bot} !== 6'b0) begin
      errors++;
      $display("FAIL midrst_panel: oe_n=%0b lat=%0b clk=%0b rgb=%b required 1 0 0 0",
               panel_oe_n, panel_lat, panel_clk, {rgb_top, rgb_bot});
    end
    vectors++;
    if (row_ready !== 1'b0 || row_idx !== 1'b0 || row_addr !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: ready=%0b idx=%0d addr=%0d required 0 0 0",
               row_ready, row_idx, row_addr);
    end
    lat0 = lat_count;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    vectors++;
    if (row_ready !== 1'b1 || row_idx !== 1'b0) begin
      errors++;
      $display("FAIL midrst_release: ready=%0b idx=%0d required 1 0", row_ready, row_idx);
    end
    exp_idx = 0;
    repeat (60) @(negedge clk);
    vectors++;
    if (lat_count != lat0) begin
      errors++;
      $display("FAIL midrst_no_latch: %0d pulses required 0", lat_count - lat0);
    end
    obs_pix.delete();
    obs_oe.delete();
  endtask

  task automatic test_idle_hold;
    row_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      vectors++;
      if (row_ready !== 1'b1 || panel_clk !== 1'b0 || panel_lat !== 1'b0 ||
          panel_oe_n !== 1'b1 || {rgb_top, rgb_bot} !== 6'b0) begin
        errors++;
        $display("FAIL idle_hold%0d: ready=%0b clk=%0b lat=%0b oe_n=%0b rgb=%b",
                 i, row_ready, panel_clk, panel_lat, panel_oe_n, {rgb_top, rgb_bot});
      end
    end
  endtask

`ifdef LED_DISPLAY_BRIGHTNESS_EN
  task automatic test_brightness;
    brightness = 8'd127;
    test_row("bright", DW'({$urandom(), $urandom()}), 127, 1'(exp_idx));
    brightness = 8'hFF;
  endtask
`endif

  initial begin
    test_reset();
    test_red_row();
    test_mixed_row();
    test_back_to_back();
    test_reset_mid();
    test_idle_hold();
`ifdef LED_DISPLAY_BRIGHTNESS_EN
    test_brightness();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
